// File: rtl/jtag_multi_tap_pkg.sv
// jtag_pkg: TAP state encoding and IR constants shared by the TAP files.
// The IEEE 1149.1 suggested 4-bit state encoding is used so that the state
// value can be compared directly against traces from other TAP models.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RTI        = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_TLR        = 4'hF
  } tap_state_e;

  // Fixed pattern loaded into the IR shift register in Capture-IR.
  localparam logic [1:0] IR_CAPTURE = 2'b01;

  // All-ones opcode (BYPASS) for an IR of the given length, up to 32 bits.
  function automatic logic [31:0] ir_all_ones(input int len);
    if (len >= 32) begin
      return '1;
    end
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/jtag_multi_tap_if.sv
// jtag_multi_tap_if: JTAG pins plus the fabric-side user-chain strobes.
// The slave modport is the TAP itself; the master modport is the probe and
// fabric logic that drives tms/tdi and returns per-chain serial data.
interface jtag_multi_tap_if #(
  parameter int NUM_CHAINS = 2
);
  logic                  tms;
  logic                  tdi;
  logic                  tdo;
  logic                  tdo_oe;
  logic                  jtck;
  logic                  jtdi;
  logic                  jshift;
  logic                  jupdate;
  logic                  jrstn;
  logic [NUM_CHAINS-1:0] jce;
  logic [NUM_CHAINS-1:0] jrti;
  logic [NUM_CHAINS-1:0] jtdo;

  modport master (
    output tms, tdi, jtdo,
    input  tdo, tdo_oe, jtck, jtdi, jshift, jupdate, jrstn, jce, jrti
  );

  modport slave (
    input  tms, tdi, jtdo,
    output tdo, tdo_oe, jtck, jtdi, jshift, jupdate, jrstn, jce, jrti
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: the 16-state IEEE 1149.1 TAP controller.
// Exposes the raw state plus one-hot flags for the states the datapath acts on.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       test_logic_reset,
  input  logic       tms,
  output tap_state_e state,
  output logic       is_tlr,
  output logic       is_rti,
  output logic       is_capture_ir,
  output logic       is_shift_ir,
  output logic       is_update_ir,
  output logic       is_capture_dr,
  output logic       is_shift_dr,
  output logic       is_update_dr
);

  tap_state_e state_q, state_d;

  // State register; reset parks the controller in Test-Logic-Reset at once.
  always_ff @(posedge tck or posedge test_logic_reset) begin
    if (test_logic_reset) begin
      state_q <= TAP_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // Standard TAP transition graph driven by tms.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TAP_TLR:        state_d = tms ? TAP_TLR       : TAP_RTI;
      TAP_RTI:        state_d = tms ? TAP_SELECT_DR : TAP_RTI;
      TAP_SELECT_DR:  state_d = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: state_d = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   state_d = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   state_d = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   state_d = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   state_d = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  state_d = tms ? TAP_SELECT_DR : TAP_RTI;
      TAP_SELECT_IR:  state_d = tms ? TAP_TLR       : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: state_d = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   state_d = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   state_d = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   state_d = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   state_d = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  state_d = tms ? TAP_SELECT_DR : TAP_RTI;
      default:        state_d = TAP_TLR;
    endcase
  end

  assign state         = state_q;
  assign is_tlr        = (state_q == TAP_TLR);
  assign is_rti        = (state_q == TAP_RTI);
  assign is_capture_ir = (state_q == TAP_CAPTURE_IR);
  assign is_shift_ir   = (state_q == TAP_SHIFT_IR);
  assign is_update_ir  = (state_q == TAP_UPDATE_IR);
  assign is_capture_dr = (state_q == TAP_CAPTURE_DR);
  assign is_shift_dr   = (state_q == TAP_SHIFT_DR);
  assign is_update_dr  = (state_q == TAP_UPDATE_DR);

endmodule

// File: rtl/jtag_multi_tap.sv
// jtag_multi_tap: generic TAP with IR, BYPASS, optional IDCODE and
// NUM_CHAINS user DR channels exposed to fabric through jce/jrti/jshift.
// Build option JTAG_IDCODE_EN: when defined the 32-bit IDCODE register exists
// and the IR resets to IDCODE_OPCODE; otherwise the IR resets to BYPASS and
// IDCODE_OPCODE decodes as BYPASS.
module jtag_multi_tap
  import jtag_pkg::*;
#(
  parameter int                           IR_LEN        = 8,
  parameter int                           NUM_CHAINS    = 2,
  parameter logic [NUM_CHAINS*IR_LEN-1:0] CHAIN_OPCODES = {8'h38, 8'h32},
  parameter logic [IR_LEN-1:0]            IDCODE_OPCODE = 8'hE0,
  parameter logic [31:0]                  IDCODE_VALUE  = 32'h0000_0001
) (
  input logic              tck,
  input logic              test_logic_reset,
  jtag_multi_tap_if.slave  bus
);

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_LEN-1:0] IR_RESET = IDCODE_OPCODE;
`else
  localparam logic [IR_LEN-1:0] IR_RESET = IR_LEN'(ir_all_ones(IR_LEN));
`endif

  tap_state_e tap_state;
  logic is_tlr, is_rti;
  logic is_capture_ir, is_shift_ir, is_update_ir;
  logic is_capture_dr, is_shift_dr, is_update_dr;

  jtag_tap_fsm u_fsm (
    .tck              (tck),
    .test_logic_reset (test_logic_reset),
    .tms              (bus.tms),
    .state            (tap_state),
    .is_tlr           (is_tlr),
    .is_rti           (is_rti),
    .is_capture_ir    (is_capture_ir),
    .is_shift_ir      (is_shift_ir),
    .is_update_ir     (is_update_ir),
    .is_capture_dr    (is_capture_dr),
    .is_shift_dr      (is_shift_dr),
    .is_update_dr     (is_update_dr)
  );

  logic [IR_LEN-1:0]     ir_q, ir_d;
  logic [IR_LEN-1:0]     ir_sr_q, ir_sr_d;
  logic                  bypass_q, bypass_d;
  logic                  jtdi_q, jtdi_d;
  logic                  tdo_q, tdo_d;
  logic                  tdo_oe_q, tdo_oe_d;
  logic                  jrstn_q, jrstn_d;
  logic [NUM_CHAINS-1:0] chain_sel;
  logic                  any_chain;
  logic                  chain_tdo;
  logic                  idcode_sel;
  logic                  bypass_sel;
  logic                  dr_tdo;

  // Opcode decode; on duplicate opcodes only the lowest-index chain is selected.
  always_comb begin
    chain_sel = '0;
    any_chain = 1'b0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      if (!any_chain && (ir_q == CHAIN_OPCODES[i*IR_LEN +: IR_LEN])) begin
        chain_sel[i] = 1'b1;
        any_chain    = 1'b1;
      end
    end
  end

  // Serial return from whichever user chain is currently selected.
  always_comb begin
    chain_tdo = 1'b0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      if (chain_sel[i]) begin
        chain_tdo = bus.jtdo[i];
      end
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] idcode_sr_q, idcode_sr_d;

  assign idcode_sel = !any_chain && (ir_q == IDCODE_OPCODE);

  // IDCODE capture/shift register, shifting toward bit 0.
  always_comb begin
    idcode_sr_d = idcode_sr_q;
    if (idcode_sel && is_capture_dr) begin
      idcode_sr_d = IDCODE_VALUE;
    end else if (idcode_sel && is_shift_dr) begin
      idcode_sr_d = {bus.tdi, idcode_sr_q[31:1]};
    end
  end

  // IDCODE register storage.
  always_ff @(posedge tck or posedge test_logic_reset) begin
    if (test_logic_reset) begin
      idcode_sr_q <= '0;
    end else begin
      idcode_sr_q <= idcode_sr_d;
    end
  end

  assign dr_tdo = any_chain  ? chain_tdo :
                  idcode_sel ? idcode_sr_q[0] : bypass_q;
`else
  assign idcode_sel = 1'b0;
  assign dr_tdo     = any_chain ? chain_tdo : bypass_q;
`endif

  assign bypass_sel = !any_chain && !idcode_sel;

  // Rising-edge datapath: IR shift/update, BYPASS bit and the jtdi copy.
  always_comb begin
    ir_d     = ir_q;
    ir_sr_d  = ir_sr_q;
    bypass_d = bypass_q;
    jtdi_d   = bus.tdi;
    if (is_tlr) begin
      ir_d = IR_RESET;
    end else if (is_update_ir) begin
      ir_d = ir_sr_q;
    end
    if (is_capture_ir) begin
      ir_sr_d = IR_LEN'(IR_CAPTURE);
    end else if (is_shift_ir) begin
      ir_sr_d = {bus.tdi, ir_sr_q[IR_LEN-1:1]};
    end
    if (bypass_sel && is_capture_dr) begin
      bypass_d = 1'b0;
    end else if (bypass_sel && is_shift_dr) begin
      bypass_d = bus.tdi;
    end
  end

  // Rising-edge registers.
  always_ff @(posedge tck or posedge test_logic_reset) begin
    if (test_logic_reset) begin
      ir_q     <= IR_RESET;
      ir_sr_q  <= '0;
      bypass_q <= 1'b0;
      jtdi_q   <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      ir_sr_q  <= ir_sr_d;
      bypass_q <= bypass_d;
      jtdi_q   <= jtdi_d;
    end
  end

  // Falling-edge outputs: tdo holds outside the shift states.
  always_comb begin
    tdo_d    = tdo_q;
    tdo_oe_d = (tap_state == TAP_SHIFT_IR) || (tap_state == TAP_SHIFT_DR);
    jrstn_d  = !is_tlr;
    if (is_shift_ir) begin
      tdo_d = ir_sr_q[0];
    end else if (is_shift_dr) begin
      tdo_d = dr_tdo;
    end
  end

  // Falling-edge registers.
  always_ff @(negedge tck or posedge test_logic_reset) begin
    if (test_logic_reset) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
      jrstn_q  <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
      jrstn_q  <= jrstn_d;
    end
  end

  assign bus.tdo     = tdo_q;
  assign bus.tdo_oe  = tdo_oe_q;
  assign bus.jtck    = tck;
  assign bus.jtdi    = jtdi_q;
  assign bus.jrstn   = jrstn_q;
  assign bus.jce     = (is_capture_dr || is_shift_dr) ? chain_sel : '0;
  assign bus.jrti    = is_rti ? chain_sel : '0;
  assign bus.jshift  = is_shift_dr && any_chain;
  assign bus.jupdate = is_update_dr && any_chain;

endmodule

// File: tb/tb_jtag_multi_tap.sv
// tb_jtag_multi_tap: directed test-plan scans followed by randomized scans,
// all checked every cycle against a queue-based TAP model.
module tb_jtag_multi_tap;

  localparam int          IR_LEN     = 8;
  localparam int          NUM_CHAINS = 2;
  localparam logic [15:0] CHAIN_OPS  = {8'h38, 8'h32};
  localparam logic [31:0] IDCODE_VAL = 32'h0000_0001;
`ifdef JTAG_IDCODE_EN
  localparam int IR_RST = 'hE0;
`else
  localparam int IR_RST = 'hFF;
`endif

  // Model state numbering (independent of the RTL encoding).
  localparam int S_TLR = 0, S_RTI = 1, S_CAPDR = 3, S_SHDR = 4, S_UPDR = 8;
  localparam int S_CAPIR = 10, S_SHIR = 11, S_UPIR = 15;

  logic tck = 1'b0;
  logic test_logic_reset;

  jtag_multi_tap_if #(.NUM_CHAINS(NUM_CHAINS)) bus ();

  jtag_multi_tap #(
    .IR_LEN        (IR_LEN),
    .NUM_CHAINS    (NUM_CHAINS),
    .CHAIN_OPCODES (CHAIN_OPS),
    .IDCODE_OPCODE (8'hE0),
    .IDCODE_VALUE  (IDCODE_VAL)
  ) dut (
    .tck              (tck),
    .test_logic_reset (test_logic_reset),
    .bus              (bus)
  );

  always #5 tck = ~tck;

  int n_compared = 0;
  int n_mismatched = 0;
  bit rand_jtdo = 1'b0;

  // Transition table: next state for tms=0 / tms=1, indexed by model state.
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int m_st;
  int m_ir;
  bit m_irq[$];
  bit m_drq[$];
  bit m_tdo, m_oe, m_jrstn, m_jtdi;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_chain();
    for (int i = 0; i < NUM_CHAINS; i++)
      if (m_ir == int'(CHAIN_OPS[i*IR_LEN +: IR_LEN])) return i;
    return -1;
  endfunction

  function automatic bit m_idsel();
`ifdef JTAG_IDCODE_EN
    return (m_chain() < 0) && (m_ir == 'hE0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic modelReset();
    m_st = S_TLR;
    m_ir = IR_RST;
    m_irq.delete();
    repeat (IR_LEN) m_irq.push_back(1'b0);
    m_drq.delete();
    m_tdo = 0; m_oe = 0; m_jrstn = 0; m_jtdi = 0;
  endtask

  task automatic modelPosedge(input bit tms_v, input bit tdi_v);
    int v;
    case (m_st)
      S_TLR: m_ir = IR_RST;
      S_CAPIR: begin
        m_irq.delete();
        m_irq.push_back(1'b1);
        repeat (IR_LEN - 1) m_irq.push_back(1'b0);
      end
      S_SHIR: begin
        void'(m_irq.pop_front());
        m_irq.push_back(tdi_v);
      end
      S_UPIR: begin
        v = 0;
        for (int i = 0; i < IR_LEN; i++) v += int'(m_irq[i]) << i;
        m_ir = v;
      end
      S_CAPDR: begin
        m_drq.delete();
        if (m_chain() < 0) begin
          if (m_idsel()) for (int i = 0; i < 32; i++) m_drq.push_back(IDCODE_VAL[i]);
          else m_drq.push_back(1'b0);
        end
      end
      S_SHDR: begin
        if (m_drq.size() > 0) begin
          void'(m_drq.pop_front());
          m_drq.push_back(tdi_v);
        end
      end
      default: ;
    endcase
    m_jtdi = tdi_v;
    m_st = tms_v ? nxt1[m_st] : nxt0[m_st];
  endtask

  task automatic modelNegedge();
    int ch;
    ch = m_chain();
    m_oe = (m_st == S_SHIR) || (m_st == S_SHDR);
    m_jrstn = (m_st != S_TLR);
    if (m_st == S_SHIR) m_tdo = m_irq[0];
    else if (m_st == S_SHDR) begin
      if (ch >= 0) m_tdo = bus.jtdo[ch];
      else if (m_drq.size() > 0) m_tdo = m_drq[0];
    end
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  task automatic checkOutput();
    int ch;
    logic [NUM_CHAINS-1:0] e_jce, e_jrti;
    ch = m_chain();
    e_jce = '0;
    e_jrti = '0;
    if (ch >= 0 && (m_st == S_CAPDR || m_st == S_SHDR)) e_jce[ch] = 1'b1;
    if (ch >= 0 && m_st == S_RTI) e_jrti[ch] = 1'b1;
    cmp("tdo", 32'(bus.tdo), 32'(m_tdo));
    cmp("tdo_oe", 32'(bus.tdo_oe), 32'(m_oe));
    cmp("jrstn", 32'(bus.jrstn), 32'(m_jrstn));
    cmp("jtdi", 32'(bus.jtdi), 32'(m_jtdi));
    cmp("jce", 32'(bus.jce), 32'(e_jce));
    cmp("jrti", 32'(bus.jrti), 32'(e_jrti));
    cmp("jshift", 32'(bus.jshift), 32'((m_st == S_SHDR) && (ch >= 0)));
    cmp("jupdate", 32'(bus.jupdate), 32'((m_st == S_UPDR) && (ch >= 0)));
    cmp("jtck", 32'(bus.jtck), 32'(tck));
  endtask

  // One tck cycle: drive inputs, advance the model on both edges, compare.
  task automatic applyStimulus(input bit tms_v, input bit tdi_v);
    bus.tms = tms_v;
    bus.tdi = tdi_v;
    if (rand_jtdo) bus.jtdo = NUM_CHAINS'($urandom);
    @(posedge tck);
    modelPosedge(tms_v, tdi_v);
    @(negedge tck);
    modelNegedge();
    #2;
    checkOutput();
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic doReset();
    #1 test_logic_reset = 1'b1;
    #1;
    modelReset();
    cmp("rst_tdo_oe", 32'(bus.tdo_oe), 32'd0);
    cmp("rst_jce", 32'(bus.jce), 32'd0);
    cmp("rst_jrstn", 32'(bus.jrstn), 32'd0);
    cmp("rst_tdo", 32'(bus.tdo), 32'd0);
    cmp("rst_jupdate", 32'(bus.jupdate), 32'd0);
    @(posedge tck);
    #2 test_logic_reset = 1'b0;
    @(negedge tck);
    modelNegedge();
    #2;
    checkOutput();
  endtask

  // Shift n bits while in Shift-xR, collecting tdo, ending in Exit1-xR.
  task automatic shiftBits(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = bus.tdo;
      applyStimulus(i == n - 1, din[i]);
    end
  endtask

  // From Run-Test/Idle: full IR scan, back to Run-Test/Idle.
  task automatic scanIr(input logic [7:0] v, output logic [7:0] out);
    logic [31:0] d;
    applyStimulus(1, 0); applyStimulus(1, 0);
    applyStimulus(0, 0); applyStimulus(0, 0);
    shiftBits(IR_LEN, 32'(v), d);
    applyStimulus(1, 0); applyStimulus(0, 0);
    out = d[7:0];
  endtask

  // From Run-Test/Idle: full DR scan of n bits, back to Run-Test/Idle.
  task automatic scanDr(input int n, input logic [31:0] din, output logic [31:0] dout);
    applyStimulus(1, 0); applyStimulus(0, 0); applyStimulus(0, 0);
    shiftBits(n, din, dout);
    applyStimulus(1, 0); applyStimulus(0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0]  ir_out;
    logic [31:0] dr_out;
    logic [7:0]  ops [5];
    test_logic_reset = 1'b1;
    bus.tms = 1'b1;
    bus.tdi = 1'b0;
    bus.jtdo = '0;
    #3;
    modelReset();
    cmp("reset_tdo", 32'(bus.tdo), 32'd0);
    cmp("reset_tdo_oe", 32'(bus.tdo_oe), 32'd0);
    cmp("reset_jrstn", 32'(bus.jrstn), 32'd0);
    cmp("reset_jtdi", 32'(bus.jtdi), 32'd0);
    @(negedge tck);
    #2 test_logic_reset = 1'b0;
    checkOutput();

    $display("[TB] five tms=1 clocks, then IR capture readback");
    repeat (5) applyStimulus(1, 0);
    cmp("tlr_jrstn", 32'(bus.jrstn), 32'd0);
    applyStimulus(0, 0);
    cmp("rti_jrstn", 32'(bus.jrstn), 32'd1);
    scanIr(8'h32, ir_out);
    cmp("ir_capture", 32'(ir_out), 32'h01);

    $display("[TB] chain 0 shift with jtdo=01");
    bus.jtdo = 2'b01;
    scanDr(4, 32'h6, dr_out);
    cmp("chain0_tdo", dr_out, 32'hF);
    cmp("chain0_jrti", 32'(bus.jrti), 32'h1);

    $display("[TB] bypass with IR=AA");
    scanIr(8'hAA, ir_out);
    scanDr(4, 32'b1101, dr_out);
    cmp("bypass_tdo", dr_out, 32'hA);

`ifdef JTAG_IDCODE_EN
    $display("[TB] IDCODE after reset");
    doReset();
    applyStimulus(0, 0);
    scanDr(32, 32'h0, dr_out);
    cmp("idcode", dr_out, 32'h0000_0001);
`else
    $display("[TB] IDCODE opcode decodes as bypass");
    scanIr(8'hE0, ir_out);
    scanDr(4, 32'b1101, dr_out);
    cmp("e0_bypass", dr_out, 32'hA);
`endif

    $display("[TB] reset in the middle of a chain 1 Shift-DR");
    scanIr(8'h38, ir_out);
    applyStimulus(1, 0); applyStimulus(0, 0); applyStimulus(0, 1);
    applyStimulus(0, 0); applyStimulus(0, 1);
    cmp("chain1_jce", 32'(bus.jce), 32'h2);
    doReset();
    applyStimulus(0, 0);
    scanDr(4, 32'b1101, dr_out);
`ifdef JTAG_IDCODE_EN
    cmp("post_reset_ir", dr_out, 32'h1);
`else
    cmp("post_reset_ir", dr_out, 32'hA);
`endif

    $display("[TB] randomized scans");
    ops = '{8'h32, 8'h38, 8'hE0, 8'hFF, 8'h00};
    rand_jtdo = 1'b1;
    for (int it = 0; it < 200; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        doReset();
        applyStimulus(0, 0);
      end else if (r <= 3) begin
        ops[4] = 8'($urandom);
        scanIr(ops[$urandom_range(0, 4)], ir_out);
      end else if (r <= 7) begin
        scanDr($urandom_range(1, 32), $urandom, dr_out);
      end else begin
        repeat (12) applyStimulus(1'($urandom), 1'($urandom));
        repeat (5) applyStimulus(1, 0);
        applyStimulus(0, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
